// File: rtl/mux8_reg.sv
// mux8_reg: 8-to-1 selector with a registered output.
// The select code is {s1,s2,s3}, with s1 as the MSB. The chosen word is captured
// on each rising clk edge when en is high. y_valid pulses for one cycle after
// every enabled capture.
// Optional build macro MUX8_PARITY_EN adds a y_par output. y_par is the even
// parity (XOR reduction) of the word held in y.
module mux8_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic [WIDTH-1:0] x5,
  input  logic [WIDTH-1:0] x6,
  input  logic [WIDTH-1:0] x7,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  output logic [WIDTH-1:0] y,
`ifdef MUX8_PARITY_EN
  output logic             y_par,
`endif
  output logic             y_valid
);

  logic [2:0]       sel;
  logic [WIDTH-1:0] sel_word;

  assign sel = {s1, s2, s3};

  // Steer the selected source. All eight codes are decoded explicitly, so an
  // unselected input (even X or Z) never reaches sel_word.
  always_comb begin
    case (sel)
      3'b000: sel_word = x0;
      3'b001: sel_word = x1;
      3'b010: sel_word = x2;
      3'b011: sel_word = x3;
      3'b100: sel_word = x4;
      3'b101: sel_word = x5;
      3'b110: sel_word = x6;
      3'b111: sel_word = x7;
    endcase
  end

  // Output register. Reset clears it immediately. With en low, y holds its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (en) begin
      y <= sel_word;
    end
  end

  // The valid pulse follows en by one cycle. It never holds over a disabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= en;
    end
  end

`ifdef MUX8_PARITY_EN
  // Parity is registered together with y, so the two are always coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_par <= 1'b0;
    end else if (en) begin
      y_par <= ^sel_word;
    end
  end
`endif

endmodule

// File: tb/tb_mux8_reg.sv
// tb_mux8_reg: runs an 8-bit and a 1-bit instance of mux8_reg side by side.
// Both instances share clk, rst, en and the select bits.
// A behavioural model predicts y, y_valid and (optionally) y_par.
module tb_mux8_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic [7:0] d8 [8];
  logic       d1 [8];

  logic [7:0] y8;
  logic       v8;
  logic       y1;
  logic       v1;
`ifdef MUX8_PARITY_EN
  logic       p8;
  logic       p1;
`endif

  logic [7:0] exp_y8;
  logic       exp_y1;
  logic       exp_v;
  logic       exp_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en),
    .x0(d8[0]), .x1(d8[1]), .x2(d8[2]), .x3(d8[3]),
    .x4(d8[4]), .x5(d8[5]), .x6(d8[6]), .x7(d8[7]),
    .s1(s1), .s2(s2), .s3(s3),
    .y(y8),
`ifdef MUX8_PARITY_EN
    .y_par(p8),
`endif
    .y_valid(v8)
  );

  mux8_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en),
    .x0(d1[0]), .x1(d1[1]), .x2(d1[2]), .x3(d1[3]),
    .x4(d1[4]), .x5(d1[5]), .x6(d1[6]), .x7(d1[7]),
    .s1(s1), .s2(s2), .s3(s3),
    .y(y1),
`ifdef MUX8_PARITY_EN
    .y_par(p1),
`endif
    .y_valid(v1)
  );

  // Even parity, computed by counting the 1 bits.
  function automatic logic parity8(input logic [7:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (w[i] === 1'b1) ones++;
    return logic'(ones % 2);
  endfunction

  task automatic set_sel(input int k);
    {s1, s2, s3} = 3'(k);
  endtask

  // The model samples the inputs present at the coming edge. The outputs are
  // then sampled 1 time unit after that edge.
  task automatic step();
    int k;
    k = int'({s1, s2, s3});
    if (rst) begin
      exp_y8 = 8'h00; exp_y1 = 1'b0; exp_v = 1'b0; exp_p = 1'b0;
    end else if (en) begin
      exp_y8 = d8[k]; exp_y1 = d1[k]; exp_v = 1'b1; exp_p = parity8(d8[k]);
    end else begin
      exp_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin d8[i] = 8'h01; d1[i] = 1'b1; end
    en = 1'b1; set_sel(0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({y8, v8, y1, v1} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_immediate: got y8=%h v8=%b y1=%b v1=%b, want all 0", y8, v8, y1, v1);
    end
    for (int n = 0; n < 2; n++) begin
      step();
      checks++;
      if ({y8, v8, y1, v1} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_edge%0d: got y8=%h v8=%b y1=%b v1=%b, want all 0", n, y8, v8, y1, v1);
      end
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if ({y8, v8, y1, v1} !== {8'h01, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: got y8=%h v8=%b y1=%b v1=%b, want 01 1 1 1", y8, v8, y1, v1);
    end
  endtask

  task automatic test_onehot();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin d1[i] = (i == k); d8[i] = 8'($urandom); end
      set_sel(k);
      step();
      checks++;
      if (y1 !== 1'b1 || y8 !== exp_y8 || v1 !== 1'b1) begin
        errors++;
        $display("FAIL onehot_sel%0d: got y1=%b y8=%h v1=%b, want 1 %h 1", k, y1, y8, v1, exp_y8);
      end
      for (int i = 0; i < 8; i++) d1[i] = (i != k);
      step();
      checks++;
      if (y1 !== 1'b0 || v1 !== 1'b1) begin
        errors++;
        $display("FAIL inverse_sel%0d: got y1=%b v1=%b, want 0 1", k, y1, v1);
      end
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 8; i++) d1[i] = 1'b0;
    d1[5] = 1'b1; s1 = 1'b1; s2 = 1'b0; s3 = 1'b1; en = 1'b1;
    step();
    checks++;
    if (y1 !== 1'b1) begin
      errors++;
      $display("FAIL directed_x5_high: got y1=%b want 1", y1);
    end
    d1[5] = 1'b0;
    step();
    checks++;
    if (y1 !== 1'b0) begin
      errors++;
      $display("FAIL directed_x5_low: got y1=%b want 0", y1);
    end
  endtask

  task automatic test_hold();
    d8[3] = 8'hA5; set_sel(3); en = 1'b1;
    step();
    checks++;
    if (y8 !== 8'hA5 || v8 !== 1'b1) begin
      errors++;
      $display("FAIL hold_capture: got y8=%h v8=%b want a5 1", y8, v8);
    end
    en = 1'b0; d8[3] = 8'h3C;
    step();
    checks++;
    if (y8 !== 8'hA5 || v8 !== 1'b0) begin
      errors++;
      $display("FAIL hold_en_low: got y8=%h v8=%b want a5 0", y8, v8);
    end
    set_sel(6); d8[6] = 8'h99;
    step();
    checks++;
    if (y8 !== 8'hA5 || v8 !== 1'b0) begin
      errors++;
      $display("FAIL hold_sel_change: got y8=%h v8=%b want a5 0", y8, v8);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      // Scramble the inputs once mid-cycle. Only the final values seen at
      // the edge should matter.
      for (int i = 0; i < 8; i++) begin d8[i] = 8'($urandom); d1[i] = 1'($urandom); end
      set_sel(int'($urandom_range(0, 7)));
      #2;
      for (int i = 0; i < 8; i++) begin d8[i] = 8'($urandom); d1[i] = 1'($urandom); end
      set_sel(int'($urandom_range(0, 7)));
      en = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if ({y8, v8, y1, v1} !== {exp_y8, exp_v, exp_y1, exp_v}) begin
        errors++;
        $display("FAIL random%0d: got y8=%h v8=%b y1=%b v1=%b, want %h %b %b %b",
                 n, y8, v8, y1, v1, exp_y8, exp_v, exp_y1, exp_v);
      end
`ifdef MUX8_PARITY_EN
      checks++;
      if (p8 !== exp_p) begin
        errors++;
        $display("FAIL random_par%0d: got y_par=%b want %b", n, p8, exp_p);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 8; i++) d8[i] = 8'($urandom);
      set_sel(n % 8);
      step();
      checks++;
      if (y8 !== exp_y8 || v8 !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d: got y8=%h v8=%b want %h 1", n, y8, v8, exp_y8);
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) d8[i] = 8'($urandom) | 8'h01;
      set_sel(n + 2);
      step();
    end
    #2 rst = 1'b1;
    #1;
    exp_y8 = 8'h00; exp_y1 = 1'b0; exp_v = 1'b0; exp_p = 1'b0;
    checks++;
    if ({y8, v8, y1, v1} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got y8=%h v8=%b y1=%b v1=%b, want all 0 before edge", y8, v8, y1, v1);
    end
`ifdef MUX8_PARITY_EN
    checks++;
    if (p8 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_par: got y_par=%b want 0", p8);
    end
`endif
    #2 rst = 1'b0;
    d8[4] = 8'h5A; set_sel(4);
    step();
    checks++;
    if (y8 !== 8'h5A || v8 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_resume: got y8=%h v8=%b want 5a 1", y8, v8);
    end
  endtask

  task automatic test_xz();
    en = 1'b1;
    for (int k = 0; k < 8; k += 3) begin
      for (int i = 0; i < 8; i++) begin d8[i] = 8'bx; d1[i] = (i % 2 == 0) ? 1'bz : 1'bx; end
      d8[k] = 8'($urandom); d1[k] = 1'($urandom);
      set_sel(k);
      step();
      checks++;
      if (y8 !== exp_y8 || y1 !== exp_y1) begin
        errors++;
        $display("FAIL xz_sel%0d: got y8=%h y1=%b want %h %b", k, y8, y1, exp_y8, exp_y1);
      end
    end
  endtask

`ifdef MUX8_PARITY_EN
  task automatic test_parity();
    en = 1'b1; set_sel(1);
    d8[1] = 8'h07;
    step();
    checks++;
    if (p8 !== 1'b1 || y8 !== 8'h07) begin
      errors++;
      $display("FAIL parity_07: got y_par=%b y8=%h want 1 07", p8, y8);
    end
    d8[1] = 8'h03;
    step();
    checks++;
    if (p8 !== 1'b0 || y8 !== 8'h03) begin
      errors++;
      $display("FAIL parity_03: got y_par=%b y8=%h want 0 03", p8, y8);
    end
    en = 1'b0; d8[1] = 8'h01;
    step();
    checks++;
    if (p8 !== 1'b0) begin
      errors++;
      $display("FAIL parity_hold: got y_par=%b want 0", p8);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) begin d8[i] = 8'h00; d1[i] = 1'b0; end
    exp_y8 = 8'h00; exp_y1 = 1'b0; exp_v = 1'b0; exp_p = 1'b0;
    test_reset();
    test_onehot();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_xz();
`ifdef MUX8_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
